// File: rtl/rx_frame_ctrl.sv
// Turns the CDC byte stream into Ethernet payload transfers: hunts preamble/SFD, skips MACs,
// filters EtherType, strips the FCS through a 5-byte pipe and keeps frame/drop statistics.
`timescale 1ns/1ps
module rx_frame_ctrl #(
  parameter logic [15:0] ETHERTYPE     = 16'h0800,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned MAC_HDR_BYTES = 12
) (
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic [7:0]  rxDataIn,
  input  logic        rxDataValidIn,
  output logic [7:0]  payloadDataOut,
  output logic        payloadValidOut,
  output logic        payloadSopOut,
  output logic        payloadEopOut,
  output logic [10:0] payloadLenOut,
  output logic        frameDropOut,
  output logic [15:0] frameCountOut,
  output logic [15:0] dropCountOut
);

  localparam logic [3:0] GAP_MAX  = 4'(GAP_CYCLES);
  localparam logic [7:0] HDR_LAST = 8'(MAC_HDR_BYTES - 1);

  typedef enum logic [2:0] {
    WAIT_GAP, IDLE, PREAMBLE, HDR, TYPE, PAYLOAD, DISCARD
  } state_t;

  state_t      state_q;
  logic [3:0]  gapCnt_q, gapCnt_d;
  logic        gapEvent;
  logic [7:0]  hdrCnt_q;
  logic [7:0]  typeHi_q;
  logic        typeSecond_q;
  logic [7:0]  pipe_q [5];
  logic [2:0]  pipeCnt_q;
  logic        emitted_q;
  logic [10:0] lenCnt_q, lenInc;
  logic [7:0]  payloadData_q;
  logic        payloadValid_q, payloadSop_q, payloadEop_q, frameDrop_q;
  logic [10:0] payloadLen_q;
  logic [15:0] frameCnt_q, dropCnt_q, frameCntInc, dropCntInc;

  // End of frame is only visible as a run of idle cycles; the event fires once per run.
  always_comb begin
    gapCnt_d = gapCnt_q;
    if (rxDataValidIn) begin
      gapCnt_d = '0;
    end else if (gapCnt_q != GAP_MAX) begin
      gapCnt_d = gapCnt_q + 4'd1;
    end
  end

  assign gapEvent    = !rxDataValidIn && (gapCnt_q == GAP_MAX - 4'd1);
  assign lenInc      = (lenCnt_q == 11'h7FF) ? lenCnt_q : lenCnt_q + 11'd1;
  assign frameCntInc = (frameCnt_q == 16'hFFFF) ? frameCnt_q : frameCnt_q + 16'd1;
  assign dropCntInc  = (dropCnt_q == 16'hFFFF) ? dropCnt_q : dropCnt_q + 16'd1;

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_q        <= WAIT_GAP;
      gapCnt_q       <= '0;
      hdrCnt_q       <= '0;
      typeHi_q       <= '0;
      typeSecond_q   <= 1'b0;
      for (int i = 0; i < 5; i++) pipe_q[i] <= '0;
      pipeCnt_q      <= '0;
      emitted_q      <= 1'b0;
      lenCnt_q       <= '0;
      payloadData_q  <= '0;
      payloadValid_q <= 1'b0;
      payloadSop_q   <= 1'b0;
      payloadEop_q   <= 1'b0;
      payloadLen_q   <= '0;
      frameDrop_q    <= 1'b0;
      frameCnt_q     <= '0;
      dropCnt_q      <= '0;
    end else begin
      gapCnt_q       <= gapCnt_d;
      payloadValid_q <= 1'b0;
      payloadSop_q   <= 1'b0;
      payloadEop_q   <= 1'b0;
      frameDrop_q    <= 1'b0;
      case (state_q)
        WAIT_GAP: begin
          if (gapEvent) state_q <= IDLE;
        end
        IDLE: begin
          if (rxDataValidIn) begin
            if (rxDataIn == 8'h55) begin
              state_q <= PREAMBLE;
            end else begin
              state_q     <= DISCARD;
              frameDrop_q <= 1'b1;
              dropCnt_q   <= dropCntInc;
            end
          end
        end
        PREAMBLE: begin
          if (rxDataValidIn) begin
            if (rxDataIn == 8'hD5) begin
              state_q  <= HDR;
              hdrCnt_q <= '0;
            end else if (rxDataIn != 8'h55) begin
              state_q     <= DISCARD;
              frameDrop_q <= 1'b1;
              dropCnt_q   <= dropCntInc;
            end
          end else if (gapEvent) begin
            state_q     <= IDLE;
            frameDrop_q <= 1'b1;
            dropCnt_q   <= dropCntInc;
          end
        end
        HDR: begin
          if (rxDataValidIn) begin
            if (hdrCnt_q == HDR_LAST) begin
              state_q      <= TYPE;
              typeSecond_q <= 1'b0;
            end else begin
              hdrCnt_q <= hdrCnt_q + 8'd1;
            end
          end else if (gapEvent) begin
            state_q     <= IDLE;
            frameDrop_q <= 1'b1;
            dropCnt_q   <= dropCntInc;
          end
        end
        TYPE: begin
          if (rxDataValidIn) begin
            if (!typeSecond_q) begin
              typeHi_q     <= rxDataIn;
              typeSecond_q <= 1'b1;
            end else if ({typeHi_q, rxDataIn} == ETHERTYPE) begin
              state_q   <= PAYLOAD;
              pipeCnt_q <= '0;
              emitted_q <= 1'b0;
              lenCnt_q  <= '0;
            end else begin
              state_q     <= DISCARD;
              frameDrop_q <= 1'b1;
              dropCnt_q   <= dropCntInc;
            end
          end else if (gapEvent) begin
            state_q     <= IDLE;
            frameDrop_q <= 1'b1;
            dropCnt_q   <= dropCntInc;
          end
        end
        PAYLOAD: begin
          // The last four bytes held at end of frame are the FCS and never leave the pipe.
          if (rxDataValidIn) begin
            pipe_q[0] <= rxDataIn;
            for (int i = 1; i < 5; i++) pipe_q[i] <= pipe_q[i-1];
            if (pipeCnt_q == 3'd5) begin
              payloadData_q  <= pipe_q[4];
              payloadValid_q <= 1'b1;
              payloadSop_q   <= !emitted_q;
              emitted_q      <= 1'b1;
              lenCnt_q       <= lenInc;
              payloadLen_q   <= lenInc;
            end else begin
              pipeCnt_q <= pipeCnt_q + 3'd1;
            end
          end else if (gapEvent) begin
            state_q <= IDLE;
            if (pipeCnt_q == 3'd5) begin
              payloadData_q  <= pipe_q[4];
              payloadValid_q <= 1'b1;
              payloadSop_q   <= !emitted_q;
              payloadEop_q   <= 1'b1;
              emitted_q      <= 1'b1;
              lenCnt_q       <= lenInc;
              payloadLen_q   <= lenInc;
              frameCnt_q     <= frameCntInc;
            end else begin
              frameDrop_q <= 1'b1;
              dropCnt_q   <= dropCntInc;
            end
          end
        end
        DISCARD: begin
          if (gapEvent) state_q <= IDLE;
        end
        default: state_q <= WAIT_GAP;
      endcase
    end
  end

  assign payloadDataOut  = payloadData_q;
  assign payloadValidOut = payloadValid_q;
  assign payloadSopOut   = payloadSop_q;
  assign payloadEopOut   = payloadEop_q;
  assign payloadLenOut   = payloadLen_q;
  assign frameDropOut    = frameDrop_q;
  assign frameCountOut   = frameCnt_q;
  assign dropCountOut    = dropCnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: a table of single frames plus hand-built sequences for
// frame merging/splitting, preamble errors, header gaps and reset in the middle of a payload.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;

  localparam int GAP = 4;

  logic        clkIn = 1'b0;
  logic        rstNIn;
  logic [7:0]  rxDataIn;
  logic        rxDataValidIn;
  logic [7:0]  payloadDataOut;
  logic        payloadValidOut, payloadSopOut, payloadEopOut, frameDropOut;
  logic [10:0] payloadLenOut;
  logic [15:0] frameCountOut, dropCountOut;

  rx_frame_ctrl #(.ETHERTYPE(16'h0800), .GAP_CYCLES(GAP), .MAC_HDR_BYTES(12)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn), .rxDataIn(rxDataIn), .rxDataValidIn(rxDataValidIn),
    .payloadDataOut(payloadDataOut), .payloadValidOut(payloadValidOut),
    .payloadSopOut(payloadSopOut), .payloadEopOut(payloadEopOut),
    .payloadLenOut(payloadLenOut), .frameDropOut(frameDropOut),
    .frameCountOut(frameCountOut), .dropCountOut(dropCountOut)
  );

  always #2 clkIn = ~clkIn;

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    logic [15:0] etherType;
    logic [7:0]  base;
    int          payLen;
    int          fcsLen;
    bit          b2b;
    bit          good;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  int expFrames = 0;
  int expDrops = 0;

  logic [7:0] monData[$];
  bit         monSop[$], monEop[$];
  int         monLen[$];
  int         monDrops = 0;
  logic [7:0] expData[$];
  bit         expSop[$], expEop[$];
  int         expLen[$];
  logic [7:0] fcsTab[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  always @(negedge clkIn) begin
    if (payloadValidOut === 1'b1) begin
      monData.push_back(payloadDataOut);
      monSop.push_back(payloadSopOut === 1'b1);
      monEop.push_back(payloadEopOut === 1'b1);
      monLen.push_back(int'(payloadLenOut));
    end
    if (frameDropOut === 1'b1) monDrops++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] b);
    @(posedge clkIn);
    #1;
    rxDataValidIn = v;
    rxDataIn = v ? b : 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic sendBytes(input byteq_t q, input bit b2b);
    foreach (q[i]) begin
      cycle(1'b1, q[i]);
      if (!b2b) cycle(1'b0, 8'h00);
    end
  endtask

  task automatic headerBytes(input logic [15:0] etherType, output byteq_t q);
    q.delete();
    repeat (7) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < 12; i++) q.push_back(8'(8'hA0 + i));
    q.push_back(etherType[15:8]);
    q.push_back(etherType[7:0]);
  endtask

  task automatic buildPayload(input logic [7:0] base, input int len, output byteq_t q);
    q.delete();
    for (int i = 0; i < len; i++) q.push_back(8'(base + i));
  endtask

  task automatic fcsBytes(input int n, output byteq_t q);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(fcsTab[i]);
  endtask

  task automatic addExpFrame(input byteq_t q);
    foreach (q[i]) begin
      expData.push_back(q[i]);
      expSop.push_back(i == 0);
      expEop.push_back(i == q.size() - 1);
      expLen.push_back((i + 1 > 2047) ? 2047 : i + 1);
    end
  endtask

  task automatic clearAll();
    monData.delete(); monSop.delete(); monEop.delete(); monLen.delete();
    expData.delete(); expSop.delete(); expEop.delete(); expLen.delete();
    monDrops = 0;
  endtask

  task automatic checkOutput(input string tag, input int expDropPulses);
    int n, dataErr, sopErr, eopErr, lenErr;
    dataErr = 0; sopErr = 0; eopErr = 0; lenErr = 0;
    check({tag, " outCount"}, monData.size(), expData.size());
    n = (monData.size() < expData.size()) ? monData.size() : expData.size();
    for (int i = 0; i < n; i++) begin
      if (monData[i] !== expData[i]) dataErr++;
      if (monSop[i] != expSop[i]) sopErr++;
      if (monEop[i] != expEop[i]) eopErr++;
      if (expEop[i] && monLen[i] != expLen[i]) lenErr++;
    end
    check({tag, " dataErrors"}, dataErr, 0);
    check({tag, " sopErrors"}, sopErr, 0);
    check({tag, " eopErrors"}, eopErr, 0);
    check({tag, " eopLenErrors"}, lenErr, 0);
    check({tag, " dropPulses"}, monDrops, expDropPulses);
    check({tag, " frameCount"}, frameCountOut, expFrames);
    check({tag, " dropCount"}, dropCountOut, expDrops);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    byteq_t hdr, pay, fcs;
    clearAll();
    headerBytes(v.etherType, hdr);
    buildPayload(v.base, v.payLen, pay);
    fcsBytes(v.fcsLen, fcs);
    sendBytes(hdr, v.b2b);
    sendBytes(pay, v.b2b);
    sendBytes(fcs, v.b2b);
    idle(GAP + 4);
    if (v.good) begin
      expFrames++;
      addExpFrame(pay);
    end else begin
      expDrops++;
    end
    checkOutput($sformatf("vec%0d", idx), v.good ? 0 : 1);
  endtask

  initial begin
    vec_t vecs[9];
    byteq_t pa, pb, pc, hdr, fcs, m, bad;

    vecs[0] = '{16'h0800, 8'h00,   46, 4, 1'b0, 1'b1};
    vecs[1] = '{16'h86DD, 8'h00,   46, 4, 1'b0, 1'b0};
    vecs[2] = '{16'h0801, 8'h00,   10, 4, 1'b0, 1'b0};
    vecs[3] = '{16'h0008, 8'h00,   10, 4, 1'b0, 1'b0};
    vecs[4] = '{16'h0800, 8'hA5,    1, 4, 1'b0, 1'b1};
    vecs[5] = '{16'h0800, 8'h00,    0, 3, 1'b0, 1'b0};
    vecs[6] = '{16'h0800, 8'h00,    0, 4, 1'b0, 1'b0};
    vecs[7] = '{16'h0800, 8'h30,    5, 4, 1'b1, 1'b1};
    vecs[8] = '{16'h0800, 8'h00, 2050, 4, 1'b1, 1'b1};

    rstNIn = 1'b0;
    rxDataValidIn = 1'b0;
    rxDataIn = 8'h00;
    idle(3);
    @(negedge clkIn);
    check("reset valid", payloadValidOut, 0);
    check("reset sop/eop/drop", {payloadSopOut, payloadEopOut, frameDropOut}, 0);
    check("reset data", payloadDataOut, 0);
    check("reset len", payloadLenOut, 0);
    check("reset counters", {frameCountOut, dropCountOut}, 0);
    rstNIn = 1'b1;
    idle(GAP + 2);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // GAP-1 idle cycles between frames must not split them.
    $display("[TB] merge sequence");
    clearAll();
    buildPayload(8'h10, 10, pa);
    buildPayload(8'h40, 8, pb);
    headerBytes(16'h0800, hdr);
    fcsBytes(4, fcs);
    sendBytes(hdr, 1'b0); sendBytes(pa, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP - 2);
    sendBytes(hdr, 1'b0); sendBytes(pb, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP + 4);
    m = {pa, fcs, hdr, pb};
    addExpFrame(m);
    expFrames++;
    checkOutput("merge", 0);

    $display("[TB] split sequence");
    clearAll();
    sendBytes(hdr, 1'b0); sendBytes(pa, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP - 1);
    sendBytes(hdr, 1'b0); sendBytes(pb, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP + 4);
    addExpFrame(pa);
    addExpFrame(pb);
    expFrames += 2;
    checkOutput("split", 0);

    $display("[TB] bad preamble sequence");
    clearAll();
    bad = '{8'h55, 8'h55, 8'h57, 8'hD5};
    sendBytes(bad, 1'b0);
    hdr.delete(); for (int i = 0; i < 12; i++) hdr.push_back(8'h55);
    sendBytes(hdr, 1'b0);
    sendBytes(pa, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP + 4);
    buildPayload(8'h60, 12, pc);
    headerBytes(16'h0800, hdr);
    sendBytes(hdr, 1'b0); sendBytes(pc, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP + 4);
    expDrops++;
    expFrames++;
    addExpFrame(pc);
    checkOutput("badPreamble", 1);

    $display("[TB] gap inside MAC header");
    clearAll();
    bad.delete();
    repeat (7) bad.push_back(8'h55);
    bad.push_back(8'hD5);
    for (int i = 0; i < 5; i++) bad.push_back(8'(8'hA0 + i));
    sendBytes(bad, 1'b0);
    idle(GAP + 4);
    expDrops++;
    checkOutput("hdrGap", 1);

    $display("[TB] reset mid-payload");
    clearAll();
    buildPayload(8'h80, 20, pa);
    sendBytes(hdr, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, pa[i]);
      if (i == 10) rstNIn = 1'b0;
      if (i == 11) begin
        rstNIn = 1'b1;
        @(negedge clkIn);
        check("midReset valid", payloadValidOut, 0);
        check("midReset len", payloadLenOut, 0);
        check("midReset data", payloadDataOut, 0);
        check("midReset frameCount", frameCountOut, 0);
        check("midReset dropCount", dropCountOut, 0);
      end
    end
    sendBytes(fcs, 1'b1);
    idle(GAP + 4);
    clearAll();
    expFrames = 0;
    expDrops = 0;
    buildPayload(8'h90, 8, pb);
    sendBytes(hdr, 1'b0); sendBytes(pb, 1'b0); sendBytes(fcs, 1'b0);
    idle(GAP + 4);
    expFrames++;
    addExpFrame(pb);
    checkOutput("afterReset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Sequences the 250 MHz byte stream leaving the rx slow_fast_cdc into Ethernet payload transfers for the book-builder parser. It hunts preamble/SFD, skips the destination and source MACs, filters on EtherType, strips the 4-byte FCS and marks payload start and end. End of frame is inferred from a gap in rdDataValid, because the CDC carries no framing sideband. It also keeps frame and drop statistics.

Parameters:
ETHERTYPE, 16'h0800, EtherType accepted. Any other EtherType discards the frame.
GAP_CYCLES, 4, consecutive invalid clkIn cycles that define end of frame. Legal range 3..15.
MAC_HDR_BYTES, 12, destination plus source MAC bytes skipped after SFD.

Ports:
clkIn  in  1  250 MHz clock (same clock as CDC rdClkIn)
rstNIn  in  1  synchronous, active-low reset
rxDataIn  in  8  byte from CDC rdDataOut
rxDataValidIn  in  1  byte strobe from CDC rdDataValidOut. No backpressure exists.
payloadDataOut  out  8  payload byte
payloadValidOut  out  1  payloadDataOut valid
payloadSopOut  out  1  first payload byte of a frame; qualified by payloadValidOut
payloadEopOut  out  1  last payload byte of a frame; qualified by payloadValidOut
payloadLenOut  out  11  payload byte count; valid with payloadEopOut
frameDropOut  out  1  one-cycle pulse per discarded frame
frameCountOut  out  16  good frames; saturates at 16'hFFFF
dropCountOut  out  16  dropped frames; saturates at 16'hFFFF

Behaviour:
Interface (decided): one clock, clkIn; reset rstNIn is synchronous, active-low.

Reset (rstNIn=0 at a clkIn edge):
- All outputs 0, counters 0, pipe empty, state WAIT_GAP.
- Reset asserted mid-frame: outputs drop the next cycle. No EOP and no drop is counted for the aborted frame.

Gap counter:
- Increments on each cycle with rxDataValidIn=0; clears on rxDataValidIn=1; saturates at GAP_CYCLES.
- A "gap event" occurs on the cycle the counter first reaches GAP_CYCLES.

States:
- WAIT_GAP: ignore bytes. On gap event -> IDLE. Entering from reset counts no drop.
- IDLE: byte 0x55 -> PREAMBLE. Any other byte -> DISCARD.
- PREAMBLE: 0x55 stays. 0xD5 (SFD) -> HDR with hdrCnt=0. Any other byte -> DISCARD.
- HDR: count bytes; after MAC_HDR_BYTES bytes -> TYPE.
- TYPE: capture 2 bytes, MSB first. Match to ETHERTYPE -> PAYLOAD; mismatch -> DISCARD.
- PAYLOAD: bytes enter a 5-deep FIFO pipe (see Payload pipe).
- DISCARD: ignore bytes; on gap event -> IDLE.

Drops:
- Every entry to DISCARD: frameDropOut pulses 1 cycle, dropCountOut+1.
- Gap event in PREAMBLE/HDR/TYPE: -> IDLE, counted as a drop.
- Gap event in IDLE: no effect.

Payload pipe:
- A byte arriving while the pipe holds 5 pushes out the oldest. That byte is registered onto payloadDataOut the next cycle with payloadValidOut=1.
- payloadSopOut=1 on the first emitted byte of the frame.
- payloadLenOut increments per emitted byte.

Gap event in PAYLOAD:
- Pipe holds 5: the oldest byte is emitted the next cycle with payloadEopOut=1. payloadLenOut equals the final count; if no byte has yet been emitted, SOP is also set. The other 4 bytes (FCS) are discarded. frameCountOut+1. -> IDLE.
- Pipe holds <5: runt, counted as a drop, nothing emitted. -> IDLE.

Other rules:
- Payload longer than 2047 bytes: payloadLenOut saturates at 2047. The frame is still forwarded.
- FCS is not checked by this block.
- At most one payload output per cycle. Back-to-back rxDataValidIn on every cycle is legal.

Test Plan:
1. Reset release, 4 idle cycles, then 7x0x55, 0xD5, 12 MAC bytes, 0x08 0x00, payload 0x00..0x2D (46 bytes), FCS DE AD BE EF, each byte on alternate cycles. Required: 46 outputs 0x00..0x2D in order; SOP on 0x00; EOP on 0x2D with payloadLenOut=46; frameCountOut=1; FCS never output.
2. Same frame with EtherType 0x86DD -> frameDropOut pulses once, dropCountOut=1, no payloadValidOut.
3. Two frames separated by exactly GAP_CYCLES-1 invalid cycles -> merged, not split: no EOP until the final gap. With a GAP_CYCLES gap -> two EOPs, frameCountOut=2.
4. Frame with 1-byte payload 0xA5 + 4 FCS bytes -> single output 0xA5 with SOP=EOP=1, len=1. Payload+FCS of only 3 bytes -> drop, dropCountOut+1.
5. Preamble 0x55 0x55 0x57 -> DISCARD, one drop; bytes of that frame ignored until gap; next clean frame forwarded.
6. rstNIn pulsed low mid-payload while bytes continue -> outputs 0 next cycle, no EOP/drop counted. Remaining bytes ignored until gap; following frame forwarded with counters starting at 0.
